// File: rtl/mem_access_unit.sv
// Bridges the MEM-stage single-cycle access interface onto a req/ack data-RAM bus,
// stalling the pipeline until the bus completes or times out. Optional MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_ren,
   input  logic                  mem_wen,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic [DATA_WIDTH-1:0] mem_din,
   output logic                  mem_stall,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_ack,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
`ifdef MEM_ALIGN_CHECK_EN
   output logic                  align_err,
`endif
   output logic                  timeout_err
);

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0]      CNT_LIMIT = CNT_W'(TIMEOUT - 1);
   localparam logic [DATA_WIDTH-1:0] TMO_DATA  = DATA_WIDTH'(32'hDEAD_BEEF);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state_q, state_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   din_q, din_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    terr_q, terr_d;
   logic                    req;
   logic                    misaligned;
`ifdef MEM_ALIGN_CHECK_EN
   logic                    align_q, align_d;
`endif

   assign req = mem_ren | mem_wen;
`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = |mem_addr[1:0];
`else
   assign misaligned = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         din_q   <= '0;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
         align_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         din_q   <= din_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
`ifdef MEM_ALIGN_CHECK_EN
         align_q <= align_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      din_d   = din_q;
      cnt_d   = cnt_q;
      terr_d  = terr_q;
`ifdef MEM_ALIGN_CHECK_EN
      align_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req) begin
               if (misaligned) begin
                  // Misaligned access never reaches the bus; reads return zero.
                  state_d = DONE;
`ifdef MEM_ALIGN_CHECK_EN
                  align_d = 1'b1;
`endif
                  if (!mem_wen) din_d = '0;
               end else begin
                  // Write wins when both strobes are set.
                  we_d    = mem_wen;
                  addr_d  = mem_addr & ~ADDR_WIDTH'(3);
                  wdata_d = mem_dout;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            // An ack landing on the limit cycle still completes normally.
            if (bus_ack) begin
               if (!we_q) din_d = bus_rdata;
               cnt_d   = '0;
               state_d = DONE;
            end else if (cnt_q == CNT_LIMIT) begin
               terr_d  = 1'b1;
               if (!we_q) din_d = TMO_DATA;
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem_stall   = ((state_q == IDLE) && req) || (state_q == BUSY);
   assign bus_req     = (state_q == BUSY);
   assign bus_we      = we_q;
   assign bus_addr    = addr_q;
   assign bus_wdata   = wdata_q;
   assign mem_din     = din_q;
   assign timeout_err = terr_q;
`ifdef MEM_ALIGN_CHECK_EN
   assign align_err   = align_q;
`endif

endmodule
